// File: rtl/dual_write_reg_file_if.sv
// Two-write/two-read register-file bus between the issue logic (master) and
// the register file (slave).
interface dual_write_reg_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 8
);
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic              ReadEn1;
    logic              ReadEn2;
    logic [ADDR_W-1:0] WriteRegister1;
    logic [ADDR_W-1:0] WriteRegister2;
    logic [DATA_W-1:0] WriteData1;
    logic [DATA_W-1:0] WriteData2;
    logic              RegWrite1;
    logic              RegWrite2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              ReadValid1;
    logic              ReadValid2;
    logic              WriteCollision;
    logic [CNT_W-1:0]  CollisionCount;

    modport master (
        output ReadRegister1, ReadRegister2, ReadEn1, ReadEn2,
               WriteRegister1, WriteRegister2, WriteData1, WriteData2,
               RegWrite1, RegWrite2,
        input  ReadData1, ReadData2, ReadValid1, ReadValid2,
               WriteCollision, CollisionCount
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, ReadEn1, ReadEn2,
               WriteRegister1, WriteRegister2, WriteData1, WriteData2,
               RegWrite1, RegWrite2,
        output ReadData1, ReadData2, ReadValid1, ReadValid2,
               WriteCollision, CollisionCount
    );
endinterface

// File: rtl/dual_write_reg_file.sv
// Dual-write/dual-read register file with registered reads, port-2-wins collision
// handling and a saturating collision counter. Optional: REGFILE_WRITE_BYPASS_EN.
module dual_write_reg_file #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned CNT_W     = 8,
    parameter bit          ZERO_HARD = 1'b0
) (
    input logic                  Clk,
    input logic                  Rst_n,
    dual_write_reg_file_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wrEn1;
    logic              wrEn2;
    logic              collision;
    logic [DATA_W-1:0] rdNext1;
    logic [DATA_W-1:0] rdNext2;

    // Effective write enables: a hardwired register 0 swallows writes, so it can
    // neither collide nor be bypassed.
    always_comb begin
        wrEn1 = bus.RegWrite1;
        wrEn2 = bus.RegWrite2;
        if (ZERO_HARD && (bus.WriteRegister1 == '0)) wrEn1 = 1'b0;
        if (ZERO_HARD && (bus.WriteRegister2 == '0)) wrEn2 = 1'b0;
        collision = wrEn1 && wrEn2 && (bus.WriteRegister1 == bus.WriteRegister2);
    end

    // Read data selection; port 2 takes precedence in the bypass path as in storage.
    always_comb begin
        rdNext1 = (ZERO_HARD && (bus.ReadRegister1 == '0)) ? '0 : mem[bus.ReadRegister1];
        rdNext2 = (ZERO_HARD && (bus.ReadRegister2 == '0)) ? '0 : mem[bus.ReadRegister2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wrEn2 && (bus.WriteRegister2 == bus.ReadRegister1)) rdNext1 = bus.WriteData2;
        else if (wrEn1 && (bus.WriteRegister1 == bus.ReadRegister1)) rdNext1 = bus.WriteData1;
        if (wrEn2 && (bus.WriteRegister2 == bus.ReadRegister2)) rdNext2 = bus.WriteData2;
        else if (wrEn1 && (bus.WriteRegister1 == bus.ReadRegister2)) rdNext2 = bus.WriteData1;
`endif
    end

    // Storage; the later port-2 assignment wins on a same-address collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wrEn1) mem[bus.WriteRegister1] <= bus.WriteData1;
            if (wrEn2) mem[bus.WriteRegister2] <= bus.WriteData2;
        end
    end

    // Registered read ports; data holds when not enabled.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.ReadData1  <= '0;
            bus.ReadData2  <= '0;
            bus.ReadValid1 <= 1'b0;
            bus.ReadValid2 <= 1'b0;
        end else begin
            bus.ReadValid1 <= bus.ReadEn1;
            bus.ReadValid2 <= bus.ReadEn2;
            if (bus.ReadEn1) bus.ReadData1 <= rdNext1;
            if (bus.ReadEn2) bus.ReadData2 <= rdNext2;
        end
    end

    // Collision pulse and saturating counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.WriteCollision <= 1'b0;
            bus.CollisionCount <= '0;
        end else begin
            bus.WriteCollision <= collision;
            if (collision && (bus.CollisionCount != '1))
                bus.CollisionCount <= bus.CollisionCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dual_write_reg_file.sv
// Directed self-checking bench for dual_write_reg_file (ZERO_HARD=0 and ZERO_HARD=1 instances).
module tb_dual_write_reg_file;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 8;

    logic Clk;
    logic Rst_n;
    int   assertCount;
    int   failCount;

    dual_write_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    dual_write_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) zhBus ();

    dual_write_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ZERO_HARD(1'b0)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    dual_write_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ZERO_HARD(1'b1)) dutZh (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (zhBus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idleMain();
        bus.ReadEn1   = 1'b0;
        bus.ReadEn2   = 1'b0;
        bus.RegWrite1 = 1'b0;
        bus.RegWrite2 = 1'b0;
    endtask

    task automatic idleZh();
        zhBus.ReadEn1   = 1'b0;
        zhBus.ReadEn2   = 1'b0;
        zhBus.RegWrite1 = 1'b0;
        zhBus.RegWrite2 = 1'b0;
    endtask

    task automatic writeMain(input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1, input logic en1,
                             input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2, input logic en2);
        bus.WriteRegister1 = a1; bus.WriteData1 = d1; bus.RegWrite1 = en1;
        bus.WriteRegister2 = a2; bus.WriteData2 = d2; bus.RegWrite2 = en2;
    endtask

    task automatic readMain(input logic [ADDR_W-1:0] a1, input logic en1,
                            input logic [ADDR_W-1:0] a2, input logic en2);
        bus.ReadRegister1 = a1; bus.ReadEn1 = en1;
        bus.ReadRegister2 = a2; bus.ReadEn2 = en2;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        Rst_n       = 1'b0;
        idleMain();
        idleZh();
        readMain('0, 1'b0, '0, 1'b0);
        writeMain('0, '0, 1'b0, '0, '0, 1'b0);
        zhBus.ReadRegister1 = '0; zhBus.ReadRegister2 = '0;
        zhBus.WriteRegister1 = '0; zhBus.WriteRegister2 = '0;
        zhBus.WriteData1 = '0; zhBus.WriteData2 = '0;
        tick();
        tick();
        checkValue("rst_rdata1", 64'(bus.ReadData1), 64'h0);
        checkValue("rst_rvalid1", 64'(bus.ReadValid1), 64'h0);
        checkValue("rst_coll", 64'(bus.WriteCollision), 64'h0);
        checkValue("rst_cnt", 64'(bus.CollisionCount), 64'h0);
        Rst_n = 1'b1;

        // Two writes to different registers in one edge, then read both back.
        writeMain(5'd3, 32'hA5, 1'b1, 5'd4, 32'h5A, 1'b1);
        tick();
        checkValue("diff_addr_no_coll", 64'(bus.WriteCollision), 64'h0);
        idleMain();
        readMain(5'd3, 1'b1, 5'd4, 1'b1);
        tick();
        checkValue("rd3", 64'(bus.ReadData1), 64'hA5);
        checkValue("rd4", 64'(bus.ReadData2), 64'h5A);
        checkValue("rvalid1", 64'(bus.ReadValid1), 64'h1);
        checkValue("rvalid2", 64'(bus.ReadValid2), 64'h1);
        idleMain();
        tick();
        checkValue("rvalid1_drop", 64'(bus.ReadValid1), 64'h0);
        checkValue("rvalid2_drop", 64'(bus.ReadValid2), 64'h0);
        checkValue("rdata1_hold", 64'(bus.ReadData1), 64'hA5);

        // Same-address collision: port 2 wins.
        writeMain(5'd1, 32'h11, 1'b1, 5'd1, 32'h22, 1'b1);
        tick();
        checkValue("coll_pulse", 64'(bus.WriteCollision), 64'h1);
        checkValue("coll_cnt1", 64'(bus.CollisionCount), 64'h1);
        idleMain();
        readMain(5'd1, 1'b1, 5'd1, 1'b1);
        tick();
        checkValue("coll_rd_p1", 64'(bus.ReadData1), 64'h22);
        checkValue("coll_rd_p2_same", 64'(bus.ReadData2), 64'h22);
        checkValue("coll_pulse_end", 64'(bus.WriteCollision), 64'h0);
        checkValue("coll_cnt_hold", 64'(bus.CollisionCount), 64'h1);

        // Only port 2 reads: port 1 valid low, data held.
        readMain(5'd3, 1'b0, 5'd4, 1'b1);
        tick();
        checkValue("p1_idle_valid", 64'(bus.ReadValid1), 64'h0);
        checkValue("p1_idle_hold", 64'(bus.ReadData1), 64'h22);
        checkValue("p2_only_data", 64'(bus.ReadData2), 64'h5A);

        // Same-edge read and write of reg10.
        idleMain();
        writeMain(5'd10, 32'h77, 1'b1, 5'd0, 32'h0, 1'b0);
        readMain(5'd10, 1'b1, 5'd10, 1'b0);
        tick();
        checkValue("same_edge_rd10", 64'(bus.ReadData1), BYPASS ? 64'h77 : 64'h0);
        idleMain();
        readMain(5'd10, 1'b1, 5'd10, 1'b0);
        tick();
        checkValue("next_rd10", 64'(bus.ReadData1), 64'h77);

        // Same-edge read during a collision on reg12.
        idleMain();
        writeMain(5'd12, 32'h33, 1'b1, 5'd12, 32'h44, 1'b1);
        readMain(5'd12, 1'b0, 5'd12, 1'b1);
        tick();
        checkValue("coll_same_edge_rd12", 64'(bus.ReadData2), BYPASS ? 64'h44 : 64'h0);
        checkValue("coll_cnt2", 64'(bus.CollisionCount), 64'h2);

        // Register 0 is ordinary storage in the default instance.
        idleMain();
        writeMain(5'd0, 32'h99, 1'b1, 5'd0, 32'h0, 1'b0);
        tick();
        idleMain();
        writeMain(5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b1);
        readMain(5'd0, 1'b1, 5'd7, 1'b1);
        tick();
        checkValue("reg0_ordinary", 64'(bus.ReadData1), 64'h99);
        checkValue("coll_cnt3", 64'(bus.CollisionCount), 64'h3);

        // Asynchronous reset between edges clears outputs immediately.
        idleMain();
        #2;
        Rst_n = 1'b0;
        #1;
        checkValue("async_rst_rdata1", 64'(bus.ReadData1), 64'h0);
        checkValue("async_rst_rvalid1", 64'(bus.ReadValid1), 64'h0);
        checkValue("async_rst_coll", 64'(bus.WriteCollision), 64'h0);
        checkValue("async_rst_cnt", 64'(bus.CollisionCount), 64'h0);
        tick();
        Rst_n = 1'b1;
        readMain(5'd3, 1'b1, 5'd1, 1'b1);
        tick();
        checkValue("post_rst_rd3", 64'(bus.ReadData1), 64'h0);
        checkValue("post_rst_rd1", 64'(bus.ReadData2), 64'h0);
        checkValue("post_rst_valid", 64'(bus.ReadValid1), 64'h1);

        // 300 consecutive collisions: counter saturates at 255.
        idleMain();
        writeMain(5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 200) checkValue("sat_cnt_200", 64'(bus.CollisionCount), 64'd200);
            if (i == 255) checkValue("sat_cnt_255", 64'(bus.CollisionCount), 64'd255);
        end
        checkValue("sat_cnt_300", 64'(bus.CollisionCount), 64'd255);
        checkValue("sat_coll_pulse", 64'(bus.WriteCollision), 64'h1);
        idleMain();

        // Hardwired register 0.
        zhBus.WriteRegister1 = 5'd0; zhBus.WriteData1 = 32'hFF; zhBus.RegWrite1 = 1'b1;
        zhBus.WriteRegister2 = 5'd0; zhBus.WriteData2 = 32'hFF; zhBus.RegWrite2 = 1'b1;
        zhBus.ReadRegister1 = 5'd0; zhBus.ReadEn1 = 1'b1;
        tick();
        checkValue("zh_same_edge_rd0", 64'(zhBus.ReadData1), 64'h0);
        checkValue("zh_no_coll", 64'(zhBus.WriteCollision), 64'h0);
        checkValue("zh_cnt0", 64'(zhBus.CollisionCount), 64'h0);
        idleZh();
        zhBus.ReadRegister1 = 5'd0; zhBus.ReadEn1 = 1'b1;
        zhBus.ReadRegister2 = 5'd0; zhBus.ReadEn2 = 1'b1;
        tick();
        checkValue("zh_rd0_p1", 64'(zhBus.ReadData1), 64'h0);
        checkValue("zh_rd0_p2", 64'(zhBus.ReadData2), 64'h0);
        checkValue("zh_rd0_valid", 64'(zhBus.ReadValid2), 64'h1);
        idleZh();
        zhBus.WriteRegister1 = 5'd2; zhBus.WriteData1 = 32'h5; zhBus.RegWrite1 = 1'b1;
        zhBus.WriteRegister2 = 5'd2; zhBus.WriteData2 = 32'h6; zhBus.RegWrite2 = 1'b1;
        tick();
        checkValue("zh_coll_reg2", 64'(zhBus.WriteCollision), 64'h1);
        idleZh();
        zhBus.ReadRegister1 = 5'd2; zhBus.ReadEn1 = 1'b1;
        tick();
        checkValue("zh_rd2", 64'(zhBus.ReadData1), 64'h6);
        idleZh();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
